// File: rtl/mem_access_pkg.sv
// Shared opcodes, stall encodings and FSM state type for the memory-access stage.
// Op codes match the EXE_*_OP values produced by the execute stage.
package mem_access_pkg;

   localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

   localparam logic        STOP          = 1'b1;
   localparam logic        NO_STOP       = 1'b0;
   localparam logic        RESET_ENABLE  = 1'b1;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam int          STALL_MEM_BIT = 4;

   typedef enum logic [1:0] {
      MEM_STATE_IDLE = 2'd0,
      MEM_STATE_BUSY = 2'd1,
      MEM_STATE_DONE = 2'd2
   } mem_state_t;

   function automatic logic is_load(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) ||
             (op == EXE_SC_OP);
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Big-endian lane steering: byte select and replicated store data on the way out,
// lane extraction with sign/zero extension on the way back.
module mem_access_load_align
   import mem_access_pkg::*;
(
   input  logic [7:0]  op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] read_word,
   input  logic [31:0] operand,
   output logic [31:0] load_data,
   output logic [3:0]  byte_select,
   output logic [31:0] write_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      lane_byte = read_word[31:24];
      case (addr_lo)
         2'b00:   lane_byte = read_word[31:24];
         2'b01:   lane_byte = read_word[23:16];
         2'b10:   lane_byte = read_word[15:8];
         default: lane_byte = read_word[7:0];
      endcase
      lane_half = addr_lo[1] ? read_word[15:0] : read_word[31:16];
   end

   always_comb begin
      load_data = read_word;
      case (op)
         EXE_LB_OP:  load_data = {{24{lane_byte[7]}}, lane_byte};
         EXE_LBU_OP: load_data = {24'h0, lane_byte};
         EXE_LH_OP:  load_data = {{16{lane_half[15]}}, lane_half};
         EXE_LHU_OP: load_data = {16'h0, lane_half};
         default:    load_data = read_word;
      endcase
   end

   always_comb begin
      byte_select = 4'b1111;
      write_data  = operand;
      case (op)
         EXE_LB_OP, EXE_LBU_OP: byte_select = 4'b1000 >> addr_lo;
         EXE_LH_OP, EXE_LHU_OP: byte_select = addr_lo[1] ? 4'b0011 : 4'b1100;
         EXE_SB_OP: begin
            byte_select = 4'b1000 >> addr_lo;
            write_data  = {4{operand[7:0]}};
         end
         EXE_SH_OP: begin
            byte_select = addr_lo[1] ? 4'b0011 : 4'b1100;
            write_data  = {2{operand[15:0]}};
         end
         default: begin
            byte_select = 4'b1111;
            write_data  = operand;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack bus and stalls
// the pipeline until the access completes; other ops pass straight through.
//
//   state | meaning
//   IDLE  | pass-through; a memory op latches the bus fields and stalls
//   BUSY  | bus_request high, fields held, waiting for bus_ack
//   DONE  | captured result presented; held while this stage is stopped
module mem_access
   import mem_access_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  op_input,
   input  logic [4:0]  write_reg_address_input,
   input  logic        write_reg_enable_input,
   input  logic [31:0] write_reg_data_input,
   input  logic [31:0] hi_input,
   input  logic [31:0] lo_input,
   input  logic        whilo_input,
   input  logic [31:0] mem_address_input,
   input  logic [31:0] store_data_input,
   input  logic        LLbit_input,
   input  logic        wb_LLbit_write_enable_input,
   input  logic        wb_LLbit_input,
   input  logic [5:0]  stop_all,
   input  logic        bus_ack,
   input  logic [31:0] bus_read_data,
   output logic        bus_request,
   output logic        bus_write_enable,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [3:0]  bus_byte_select,
   output logic        stall_request,
   output logic [4:0]  mem_write_reg_address_output,
   output logic        mem_write_reg_enable_output,
   output logic [31:0] mem_write_reg_data_output,
   output logic [31:0] mem_hi_output,
   output logic [31:0] mem_lo_output,
   output logic        mem_whilo_output,
   output logic        mem_LLbit_write_enable_output,
   output logic        mem_LLbit_output
);

   mem_state_t  state_q;
   logic [7:0]  op_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] result_q;

   logic        llbit_eff;
   logic        sc_fail;
   logic        mem_op;
   logic [7:0]  align_op;
   logic [1:0]  align_addr_lo;
   logic [31:0] align_load_data;
   logic [3:0]  align_select;
   logic [31:0] align_write_data;
   logic        unused_stop_bits;

   assign unused_stop_bits = ^{stop_all[5], stop_all[3:0]};

   assign llbit_eff = wb_LLbit_write_enable_input ? wb_LLbit_input : LLbit_input;
   assign sc_fail   = (op_input == EXE_SC_OP) && !llbit_eff;
   assign mem_op    = (is_load(op_input) || is_store(op_input)) && !sc_fail;

   // Lane steering follows the live op in IDLE and the latched op afterwards.
   assign align_op      = (state_q == MEM_STATE_IDLE) ? op_input : op_q;
   assign align_addr_lo = (state_q == MEM_STATE_IDLE) ? mem_address_input[1:0] : addr_lo_q;

   mem_access_load_align u_align (
      .op          (align_op),
      .addr_lo     (align_addr_lo),
      .read_word   (bus_read_data),
      .operand     (store_data_input),
      .load_data   (align_load_data),
      .byte_select (align_select),
      .write_data  (align_write_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset == RESET_ENABLE) begin
         state_q          <= MEM_STATE_IDLE;
         op_q             <= EXE_NOP_OP;
         addr_lo_q        <= 2'b00;
         result_q         <= ZERO_WORD;
         bus_request      <= 1'b0;
         bus_write_enable <= 1'b0;
         bus_address      <= ZERO_WORD;
         bus_write_data   <= ZERO_WORD;
         bus_byte_select  <= 4'b0000;
      end else begin
         case (state_q)
            MEM_STATE_IDLE: begin
               if (mem_op) begin
                  op_q             <= op_input;
                  addr_lo_q        <= mem_address_input[1:0];
                  bus_address      <= {mem_address_input[31:2], 2'b00};
                  bus_byte_select  <= align_select;
                  bus_write_data   <= align_write_data;
                  bus_write_enable <= is_store(op_input);
                  bus_request      <= 1'b1;
                  state_q          <= MEM_STATE_BUSY;
               end
            end
            MEM_STATE_BUSY: begin
               if (bus_ack) begin
                  // A store that reached the bus as SC is by construction a successful SC.
                  result_q         <= (op_q == EXE_SC_OP) ? 32'd1 : align_load_data;
                  bus_request      <= 1'b0;
                  bus_write_enable <= 1'b0;
                  state_q          <= MEM_STATE_DONE;
               end
            end
            MEM_STATE_DONE: begin
               if (stop_all[STALL_MEM_BIT] == NO_STOP) begin
                  state_q <= MEM_STATE_IDLE;
               end
            end
            default: state_q <= MEM_STATE_IDLE;
         endcase
      end
   end

   assign stall_request = ((state_q == MEM_STATE_IDLE) && mem_op) ||
                          (state_q == MEM_STATE_BUSY);

   always_comb begin
      mem_write_reg_address_output  = write_reg_address_input;
      mem_write_reg_enable_output   = write_reg_enable_input;
      mem_write_reg_data_output     = write_reg_data_input;
      mem_hi_output                 = hi_input;
      mem_lo_output                 = lo_input;
      mem_whilo_output              = whilo_input;
      mem_LLbit_write_enable_output = 1'b0;
      mem_LLbit_output              = 1'b0;
      if (state_q == MEM_STATE_DONE) begin
         if (is_load(op_q) || (op_q == EXE_SC_OP)) begin
            mem_write_reg_data_output = result_q;
         end
         if (op_q == EXE_LL_OP) begin
            mem_LLbit_write_enable_output = 1'b1;
            mem_LLbit_output              = 1'b1;
         end else if (op_q == EXE_SC_OP) begin
            mem_LLbit_write_enable_output = 1'b1;
            mem_LLbit_output              = 1'b0;
         end
      end else if (sc_fail) begin
         mem_write_reg_data_output = ZERO_WORD;
      end
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage pipeline, between `ex_mem` and `mem_wb`. Executes LB/LBU/LH/LHU/LW/LL/SB/SH/SW/SC over a request/acknowledge data bus, stalls the pipeline until the access completes, and produces the register, HI/LO and LLbit write-back fields consumed by `mem_wb`. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- No parameters. Widths come from `defines.v` (`RegisterBus` 32, `RegisterAddressBus` 5, `AluOpBus` 8, `StopAllBus` 6).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op_input` in 8: ALU op from `ex_mem` (`EXE_*_OP` codes).
- `write_reg_address_input` / `write_reg_enable_input` / `write_reg_data_input` in 5/1/32: pass-through write-back fields.
- `hi_input`, `lo_input` in 32 each; `whilo_input` in 1: pass-through.
- `mem_address_input` in 32: effective address.
- `store_data_input` in 32: rt operand for stores.
- `LLbit_input` in 1: current LLbit register value.
- `wb_LLbit_write_enable_input`, `wb_LLbit_input` in 1 each: forwarding from `mem_wb` outputs.
- `stop_all` in 6: pipeline stall vector; bit 4 is this stage.
- `bus_ack` in 1; `bus_read_data` in 32.
- `bus_request`, `bus_write_enable` out 1 each; `bus_address`, `bus_write_data` out 32; `bus_byte_select` out 4.
- `stall_request` out 1: to stall controller.
- `mem_write_reg_address_output`, `mem_write_reg_enable_output`, `mem_write_reg_data_output`, `mem_hi_output`, `mem_lo_output`, `mem_whilo_output`, `mem_LLbit_write_enable_output`, `mem_LLbit_output` out: to `mem_wb`.

## Operation
- Effective LLbit = `wb_LLbit_input` when `wb_LLbit_write_enable_input`, else `LLbit_input`.
- FSM states: IDLE, BUSY, DONE.
- IDLE, non-memory op, or SC with effective LLbit 0: outputs equal inputs, `stall_request`=0. The failed SC writes 0 to rt with no bus access.
- IDLE, memory op: `stall_request`=1. Register `bus_address`={addr[31:2],2'b00}, byte select, write data and write enable, then go to BUSY.
- BUSY: `bus_request`=1. Address, data and select are held stable until `bus_ack`. On ack, capture the load data (extended) into the result register, drop the request, and go to DONE. `stall_request`=1 throughout.
- DONE: `stall_request`=0 and outputs use the captured result. Stay in DONE while `stop_all[4]`=Stop. Return to IDLE on the first cycle with NoStop.
- Big-endian lane mapping: addr[1:0]=00 maps to select 1000 and bits [31:24]; 11 maps to 0001 and bits [7:0]. Halfword uses addr[1]: 0 gives 1100 and [31:16]; 1 gives 0011. Word uses 1111.
- Byte/halfword stores replicate the operand across all lanes. LB/LH sign-extend; LBU/LHU zero-extend.
- LL: a load word that also sets `mem_LLbit_write_enable_output`=1 and `mem_LLbit_output`=1.
- Successful SC: a word store that writes 1 to rt and sets LLbit write enable 1 with value 0.
- Stores: `write_reg_enable` passes through from the input (0 for SB/SH/SW).
- Misalignment is not checked; the low address bits only select lanes.

## Timing
- Reset (async) forces IDLE. Reset value is 0 for `bus_request`, `bus_write_enable`, `bus_address`, `bus_write_data`, `bus_byte_select` and the captured result register. Combinational outputs follow the IDLE rules.
- Memory op latency: at least 3 cycles, i.e. 1 cycle each in IDLE, BUSY-with-ack and DONE. Each extra ack wait adds one cycle.
- `bus_ack` is ignored outside BUSY.
- Reset during BUSY drops `bus_request` immediately, and the access is abandoned.
- Inputs are held by the upstream stall while `stall_request`=1. The block registers them on IDLE exit anyway.

## Structure
- New op codes, if any, and the `Stop`/`NoStop`, `ResetEnable` and `ZeroWord` macros stay in `defines.v`. FSM state encodings go in `defines.v` as `MemState*`.
- One natural sub-module: `mem_load_align`, a combinational block that maps (op, addr[1:0], bus word) to the extended result and (op, addr[1:0], operand) to select and write data.

## Test plan
- ADD op passes through, e.g. data 0x12345678 to r5. Outputs match the inputs the same cycle, `stall_request`=0, and no bus request is issued.
- LB at addr 0x103 with bus word 0x000000F0 and ack on the 2nd BUSY cycle: select 0001, result 0xFFFFFFF0. `stall_request` is high for 3 cycles.
- SH at addr 0x102 with rt 0x0000ABCD: `bus_address` 0x100, select 0011, write data 0xABCDABCD, write enable 1, reg write enable 0.
- LL at 0x200 followed by SC at 0x200 with the LLbit forwarded from `mem_wb`: the SC stores and writes 1 to rt, and LLbit write enable is 1 with value 0. SC with LLbit 0 writes 0 to rt, gives no bus request and no stall.
- LW completes while `stop_all[4]` is held at Stop for 4 cycles: the FSM stays in DONE and the result is stable. It returns to IDLE on the first NoStop cycle.
- Reset asserted in BUSY before ack: `bus_request` goes to 0 without waiting for a clock edge, the state is IDLE, and a later ack is ignored.
